alu_issue_wb: RTL and testbench
===============================

// Module: alu_issue_wb
// PURPOSE
//  Register-file, PSW and sequencing stage wrapped around the combinational ALU.
//  Accepts one decoded register/constant instruction per handshake from the decoder.
//  Reads the operands, drives the ALU, captures result and PSW_o, then writes back.
//  Owns R0-R7 and the PSW (bits V=4, S=3, N=2, Z=1, C=0).
// PARAMETERS
//  NREG    8   number of general registers (address width fixed at 3)
//  DW      16  datapath width
// PORTS
//  clk          in   1   single system clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  dec_valid    in   1   decoder holds an instruction
//  dec_ready    out  1   stage can accept (IDLE only)
//  dec_instr    in   5   ALU op code 00000-11011; bit0 = byte mode
//  dec_rc       in   1   1: src field indexes constant table; 0: register
//  dec_src      in   3   source register / constant index
//  dec_dst      in   3   destination register
//  dec_psw_upd  in   1   PSW update enable, forwarded as ALU instr_opt
//  alu_op1      out  16  ALU op1 = R[dst] (registered)
//  alu_op2      out  16  ALU op2 = src operand (registered)
//  alu_instr    out  6   {1'b0, latched dec_instr}
//  alu_opt      out  1   latched dec_psw_upd
//  alu_psw_i    out  16  current PSW register
//  alu_result   in   16  ALU result (combinational from alu_op*)
//  alu_psw_o    in   16  ALU PSW out
//  wb_done      out  1   one-cycle pulse in WB state
//  illegal      out  1   one-cycle pulse in WB when op code 11100-11111
//  psw          out  16  PSW register
//  dbg_addr     in   3   debug read address
//  dbg_data     out  16  R[dbg_addr], combinational
// BEHAVIOUR
//  FSM: IDLE -> OPER -> EXEC -> WB -> IDLE; one instruction in flight, no overlap.
//  IDLE: dec_ready=1. On dec_valid & dec_ready, latch instr, rc, src, dst and psw_upd,
//   then go to OPER. dec_valid without ready is ignored and the decoder must hold it.
//  OPER: alu_op1 <= R[dst]; alu_op2 <= rc ? CONST[src] : R[src].
//   CONST = {0,1,2,4,8,16,32,16'hFFFF} for index 0-7.
//  EXEC: ALU settles on the registered operands. Capture res_q <= alu_result and
//   psw_q <= alu_psw_o.
//  WB: wb_done=1. At the exit edge R[dst] <= res_q and PSW <= psw_q, except:
//   - cmp/cmp.b (0101x) and bit/bit.b (1001x): no register write; PSW is still written.
//   - op 111xx: no register write, PSW unchanged, illegal=1.
//  PSW write uses psw_q unconditionally; the ALU already returns PSW_i when opt=0.
//  Byte ops: R[dst][15:8] is written with whatever the ALU returns. No masking here.
//  Latency: accept at edge N, write visible after edge N+3, dec_ready high again in N+3.
//  Throughput: 1 instruction per 4 clocks.
//  src == dst with rc=0: both operands read the same pre-instruction value.
//  alu_op1, alu_op2, alu_instr and alu_opt hold their last values outside OPER/EXEC.
//  Reset (any state, including mid-instruction): state=IDLE, R0-R7=0, PSW=0, res_q=0,
//   psw_q=0, alu_op1/op2=0, alu_instr=0, alu_opt=0, wb_done=0, illegal=0.
//   dec_ready=0 while rst is high and 1 from the first cycle after.
//   An aborted instruction performs no write.
//  dbg_data reads the register array directly and shows writes the cycle after WB.
// TESTING
//  - Reset, then add R1,R2 with R1=0x0005, R2=0x0003, psw_upd=1 -> R1=0x0008,
//    PSW=0x0000, wb_done 3 cycles after accept.
//  - Constant add: R0=0x7FFF, rc=1, src=1, add, upd=1 -> R0=0x8000, V=1, N=1, C=0.
//  - cmp R3,R3 with R3=0x1234, upd=1 -> R3 unchanged 0x1234, Z=1.
//  - dec_valid held high for back-to-back ops -> accepted only in IDLE, 4 cycles apart,
//    second op sees the first op's result.
//  - Op 11101 -> illegal pulse, all registers and PSW unchanged, FSM back in IDLE.
//  - Assert rst during EXEC of add R4 -> R4=0, PSW=0, no wb_done, dec_ready=1 next cycle.

Source files
------------

// File: rtl/alu_issue_wb.sv
// Register-file, PSW and sequencing stage around an external combinational ALU.
// One instruction is in flight at a time: IDLE -> OPER -> EXEC -> WB -> IDLE.
module alu_issue_wb #(
  parameter int unsigned NREG = 8,
  parameter int unsigned DW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_valid,
  output logic          dec_ready,
  input  logic [4:0]    dec_instr,
  input  logic          dec_rc,
  input  logic [2:0]    dec_src,
  input  logic [2:0]    dec_dst,
  input  logic          dec_psw_upd,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  output logic [5:0]    alu_instr,
  output logic          alu_opt,
  output logic [15:0]   alu_psw_i,
  input  logic [DW-1:0] alu_result,
  input  logic [15:0]   alu_psw_o,
  output logic          wb_done,
  output logic          illegal,
  output logic [15:0]   psw,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StOper, StExec, StWb} state_e;

  state_e        state_q;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] res_q;
  logic [15:0]   psw_q;
  logic [4:0]    instr_q;
  logic          rc_q;
  logic [2:0]    src_q;
  logic [2:0]    dst_q;
  logic          upd_q;

  logic          is_illegal;
  logic          no_reg_write;

  // Constant table selected when rc is set.
  function automatic logic [DW-1:0] const_val(input logic [2:0] idx);
    logic [DW-1:0] v;
    unique case (idx)
      3'd0:    v = '0;
      3'd1:    v = DW'(1);
      3'd2:    v = DW'(2);
      3'd3:    v = DW'(4);
      3'd4:    v = DW'(8);
      3'd5:    v = DW'(16);
      3'd6:    v = DW'(32);
      default: v = '1;
    endcase
    return v;
  endfunction

  // Decode of the latched op code for the write-back stage.
  always_comb begin
    is_illegal   = (instr_q[4:2] == 3'b111);
    // cmp (0101x) and bit (1001x) only update flags
    no_reg_write = is_illegal || (instr_q[4:1] == 4'b0101) || (instr_q[4:1] == 4'b1001);
  end

  // Sequencer, register file, PSW and registered ALU operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
      psw     <= '0;
      res_q   <= '0;
      psw_q   <= '0;
      alu_op1 <= '0;
      alu_op2 <= '0;
      instr_q <= '0;
      rc_q    <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      upd_q   <= 1'b0;
      wb_done <= 1'b0;
      illegal <= 1'b0;
    end else begin
      wb_done <= 1'b0;
      illegal <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (dec_valid) begin
            instr_q <= dec_instr;
            rc_q    <= dec_rc;
            src_q   <= dec_src;
            dst_q   <= dec_dst;
            upd_q   <= dec_psw_upd;
            state_q <= StOper;
          end
        end
        StOper: begin
          // Both operands read the pre-instruction register contents.
          alu_op1 <= rf_q[dst_q];
          alu_op2 <= rc_q ? const_val(src_q) : rf_q[src_q];
          state_q <= StExec;
        end
        StExec: begin
          res_q   <= alu_result;
          psw_q   <= alu_psw_o;
          wb_done <= 1'b1;
          illegal <= is_illegal;
          state_q <= StWb;
        end
        StWb: begin
          if (!no_reg_write) rf_q[dst_q] <= res_q;
          // ALU already passes PSW through when the update option is clear.
          if (!is_illegal) psw <= psw_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake and pass-through outputs.
  always_comb begin
    dec_ready = (state_q == StIdle) && !rst;
    alu_instr = {1'b0, instr_q};
    alu_opt   = upd_q;
    alu_psw_i = psw;
    dbg_data  = rf_q[dbg_addr];
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Self-checking bench for alu_issue_wb with a behavioural ALU and a write-back scoreboard.
module tb_alu_issue_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_instr;
  logic        dec_rc;
  logic [2:0]  dec_src;
  logic [2:0]  dec_dst;
  logic        dec_psw_upd;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [5:0]  alu_instr;
  logic        alu_opt;
  logic [15:0] alu_psw_i;
  logic [15:0] alu_result;
  logic [15:0] alu_psw_o;
  logic        wb_done;
  logic        illegal;
  logic [15:0] psw;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  // Ops understood by the behavioural ALU
  localparam logic [4:0] OpMov = 5'b00000;
  localparam logic [4:0] OpAdd = 5'b00100;
  localparam logic [4:0] OpSrl = 5'b00110;
  localparam logic [4:0] OpCmp = 5'b01010;
  localparam logic [4:0] OpNib = 5'b01100;
  localparam logic [4:0] OpIll = 5'b11101;

  typedef struct {
    logic [2:0]  dst;
    logic [15:0] res;
    logic [15:0] psw;
    logic        ill;
  } exp_t;

  exp_t        sbq[$];
  exp_t        cur;
  logic [15:0] m_r [8];
  logic [15:0] m_psw;
  logic [15:0] cst [8];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_pend = 1'b0;
  logic [2:0]  mon_addr = '0;
  logic [2:0]  tb_addr  = '0;
  time         acc_time;

  always #5 clk = ~clk;

  assign dbg_addr = mon_pend ? mon_addr : tb_addr;

  // Behavioural ALU: returns {result, psw_out}
  function automatic logic [31:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [4:0] op, input logic opt,
                                        input logic [15:0] pi);
    logic [16:0] s;
    logic [15:0] r;
    logic [15:0] po;
    logic        c;
    logic        v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op[4:1])
      4'b0000: r = b;
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'b0011: r = b >> 1;
      4'b0101: begin
        r = a - b;
        c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'b0110: r = (a << 4) + b;
      4'b1001: r = a & b;
      default: r = a ^ b;
    endcase
    if (op[0]) r[15:8] = a[15:8];
    po = opt ? {11'b0, v, r[15] ^ v, r[15], (r == 16'h0), c} : pi;
    return {r, po};
  endfunction

  assign {alu_result, alu_psw_o} = alu_f(alu_op1, alu_op2, alu_instr[4:0], alu_opt, alu_psw_i);

  alu_issue_wb #(.NREG(8), .DW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_instr  (dec_instr),
    .dec_rc     (dec_rc),
    .dec_src    (dec_src),
    .dec_dst    (dec_dst),
    .dec_psw_upd(dec_psw_upd),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_instr  (alu_instr),
    .alu_opt    (alu_opt),
    .alu_psw_i  (alu_psw_i),
    .alu_result (alu_result),
    .alu_psw_o  (alu_psw_o),
    .wb_done    (wb_done),
    .illegal    (illegal),
    .psw        (psw),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Scoreboard: pops on every wb_done, checks the written register and PSW one cycle later
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mon_pend) begin
        n_tests++;
        if (dbg_data !== cur.res || psw !== cur.psw) begin
          n_fail++;
          $display("FAIL sb_writeback R%0d=%h psw=%h, expected R%0d=%h psw=%h",
                   cur.dst, dbg_data, psw, cur.dst, cur.res, cur.psw);
        end
        mon_pend = 1'b0;
      end
      if (wb_done === 1'b1) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_wb wb_done=1, expected no write-back");
        end else begin
          cur = sbq.pop_front();
          if (illegal !== cur.ill) begin
            n_fail++;
            $display("FAIL sb_illegal illegal=%b, expected %b", illegal, cur.ill);
          end
          mon_addr = cur.dst;
          mon_pend = 1'b1;
        end
      end
    end
  endtask

  // Issue one instruction (called at a negedge); returns at the negedge after acceptance
  task automatic send(input logic [4:0] op, input logic rc, input logic [2:0] src,
                      input logic [2:0] dst, input logic upd, input bit hold, input bit track);
    logic [31:0] rp;
    logic        ill;
    logic        nowr;
    exp_t        e;
    int          waited;
    if (track) begin
      rp   = alu_f(m_r[dst], rc ? cst[src] : m_r[src], op, upd, m_psw);
      ill  = (op[4:2] == 3'b111);
      nowr = ill || (op[4:1] == 4'b0101) || (op[4:1] == 4'b1001);
      if (!nowr) m_r[dst] = rp[31:16];
      if (!ill) m_psw = rp[15:0];
      e.dst = dst; e.res = m_r[dst]; e.psw = m_psw; e.ill = ill;
      sbq.push_back(e);
    end
    dec_instr = op; dec_rc = rc; dec_src = src; dec_dst = dst; dec_psw_upd = upd;
    dec_valid = 1'b1;
    waited = 0;
    while (dec_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (dec_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout dec_ready=%b, expected 1 within 40 cycles", dec_ready);
      dec_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_time = $time;
    @(negedge clk);
    if (!hold) dec_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (sbq.size() == 0 && !mon_pend && dec_ready === 1'b1 && !dec_valid) return;
      @(negedge clk);
    end
    n_tests++; n_fail++;
    $display("FAIL idle_timeout pending=%0d, expected 0 within 60 cycles", sbq.size());
  endtask

  task automatic test_reset();
    rst = 1'b1; dec_valid = 1'b0; dec_instr = '0; dec_rc = 1'b0; dec_src = '0;
    dec_dst = '0; dec_psw_upd = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (dec_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_in_rst dec_ready=%b, expected 0", dec_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (dec_ready !== 1'b1 || wb_done !== 1'b0 || illegal !== 1'b0 || psw !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs ready=%b wb=%b ill=%b psw=%h, expected 1 0 0 0000",
               dec_ready, wb_done, illegal, psw);
    end
    n_tests++;
    if (alu_op1 !== 16'h0 || alu_op2 !== 16'h0 || alu_instr !== 6'h0 || alu_opt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_alu_regs op1=%h op2=%h instr=%h opt=%b, expected all 0",
               alu_op1, alu_op2, alu_instr, alu_opt);
    end
    for (int i = 0; i < 8; i++) begin
      tb_addr = 3'(i);
      #1;
      n_tests++;
      if (dbg_data !== 16'h0) begin
        n_fail++; $display("FAIL reset_reg R%0d=%h, expected 0000", i, dbg_data);
      end
    end
  endtask

  task automatic test_add();
    send(OpMov, 1'b1, 3'd3, 3'd1, 1'b0, 1'b0, 1'b1);  // R1 = 4
    send(OpAdd, 1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1);  // R1 = 5
    send(OpMov, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 1'b1);  // R2 = 2
    send(OpAdd, 1'b1, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1);  // R2 = 3
    wait_idle();
    send(OpAdd, 1'b0, 3'd2, 3'd1, 1'b1, 1'b0, 1'b1);  // add R1,R2
    // Now in OPER (accept edge N); EXEC after N+1, WB after N+2, IDLE after N+3
    @(negedge clk);
    n_tests++;
    if (wb_done !== 1'b0) begin
      n_fail++; $display("FAIL add_wb_early wb_done=%b in EXEC, expected 0", wb_done);
    end
    @(negedge clk);
    n_tests++;
    if (wb_done !== 1'b1 || dec_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL add_wb_latency wb=%b ready=%b in WB, expected 1 0", wb_done, dec_ready);
    end
    @(negedge clk);
    n_tests++;
    if (dec_ready !== 1'b1 || wb_done !== 1'b0) begin
      n_fail++;
      $display("FAIL add_ready_back ready=%b wb=%b, expected 1 0", dec_ready, wb_done);
    end
    wait_idle();
    tb_addr = 3'd1;
    #1;
    n_tests++;
    if (dbg_data !== 16'h0008 || psw !== 16'h0000) begin
      n_fail++;
      $display("FAIL add_result R1=%h psw=%h, expected 0008 0000", dbg_data, psw);
    end
  endtask

  task automatic test_const_add();
    send(OpMov, 1'b1, 3'd7, 3'd0, 1'b0, 1'b0, 1'b1);  // R0 = FFFF
    send(OpSrl, 1'b1, 3'd7, 3'd0, 1'b0, 1'b0, 1'b1);  // R0 = 7FFF
    send(OpAdd, 1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1);  // R0 += 1
    wait_idle();
    tb_addr = 3'd0;
    #1;
    n_tests++;
    if (dbg_data !== 16'h8000 || psw[4] !== 1'b1 || psw[2] !== 1'b1 || psw[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL const_add R0=%h psw=%h, expected 8000 with V=1 N=1 C=0", dbg_data, psw);
    end
    n_tests++;
    if (psw !== 16'h0014) begin
      n_fail++; $display("FAIL const_add_psw psw=%h, expected 0014", psw);
    end
  endtask

  task automatic test_cmp();
    send(OpMov, 1'b1, 3'd1, 3'd3, 1'b0, 1'b0, 1'b1);  // 0x0001
    send(OpNib, 1'b1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b1);  // 0x0012
    send(OpNib, 1'b1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b1);  // 0x0122
    send(OpAdd, 1'b1, 3'd1, 3'd3, 1'b0, 1'b0, 1'b1);  // 0x0123
    send(OpNib, 1'b1, 3'd3, 3'd3, 1'b0, 1'b0, 1'b1);  // 0x1234
    send(OpCmp, 1'b0, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1);  // cmp R3,R3
    wait_idle();
    tb_addr = 3'd3;
    #1;
    n_tests++;
    if (dbg_data !== 16'h1234 || psw[1] !== 1'b1) begin
      n_fail++; $display("FAIL cmp_same R3=%h psw=%h, expected 1234 with Z=1", dbg_data, psw);
    end
    n_tests++;
    if (psw !== 16'h0002) begin
      n_fail++; $display("FAIL cmp_psw psw=%h, expected 0002", psw);
    end
  endtask

  task automatic test_back_to_back();
    time t1;
    time t2;
    time t3;
    send(OpAdd, 1'b1, 3'd1, 3'd5, 1'b0, 1'b1, 1'b1);
    t1 = acc_time;
    send(OpAdd, 1'b1, 3'd1, 3'd5, 1'b0, 1'b1, 1'b1);
    t2 = acc_time;
    send(OpAdd, 1'b1, 3'd2, 3'd5, 1'b0, 1'b0, 1'b1);
    t3 = acc_time;
    wait_idle();
    n_tests++;
    if (t2 - t1 != 40 || t3 - t2 != 40) begin
      n_fail++;
      $display("FAIL b2b_spacing gaps=%0t,%0t, expected 40,40", t2 - t1, t3 - t2);
    end
    tb_addr = 3'd5;
    #1;
    n_tests++;
    if (dbg_data !== 16'h0004) begin
      n_fail++; $display("FAIL b2b_chain R5=%h, expected 0004", dbg_data);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] psw_before;
    bit          seen;
    psw_before = psw;
    seen = 1'b0;
    send(OpIll, 1'b1, 3'd7, 3'd3, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5 && !seen; i++) begin
      if (wb_done === 1'b1) begin
        seen = 1'b1;
        n_tests++;
        if (illegal !== 1'b1) begin
          n_fail++; $display("FAIL illegal_pulse illegal=%b, expected 1", illegal);
        end
      end else begin
        @(negedge clk);
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL illegal_wb wb_done=0, expected a pulse");
    end
    wait_idle();
    n_tests++;
    if (psw !== psw_before || psw !== 16'h0002) begin
      n_fail++; $display("FAIL illegal_psw psw=%h, expected 0002", psw);
    end
    for (int i = 0; i < 8; i++) begin
      tb_addr = 3'(i);
      #1;
      n_tests++;
      if (dbg_data !== m_r[i]) begin
        n_fail++; $display("FAIL illegal_regs R%0d=%h, expected %h", i, dbg_data, m_r[i]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (dec_ready !== 1'b1 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_idle ready=%b ill=%b, expected 1 0", dec_ready, illegal);
    end
  endtask

  task automatic test_reset_mid();
    bit seen_wb;
    send(OpMov, 1'b1, 3'd4, 3'd4, 1'b0, 1'b0, 1'b1);  // R4 = 8
    send(OpCmp, 1'b0, 3'd4, 3'd4, 1'b1, 1'b0, 1'b1);  // Z=1
    wait_idle();
    n_tests++;
    if (psw !== 16'h0002) begin
      n_fail++; $display("FAIL rstmid_pre psw=%h, expected 0002", psw);
    end
    send(OpAdd, 1'b1, 3'd1, 3'd4, 1'b1, 1'b0, 1'b0);  // aborted, not tracked
    @(negedge clk);  // EXEC
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (dec_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ready_in_rst dec_ready=%b, expected 0", dec_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (dec_ready !== 1'b1 || wb_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_ready ready=%b wb=%b, expected 1 0", dec_ready, wb_done);
    end
    seen_wb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (wb_done === 1'b1) seen_wb = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (seen_wb) begin
      n_fail++; $display("FAIL rstmid_no_wb wb_done seen=1, expected 0");
    end
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_psw = '0;
    tb_addr = 3'd4;
    #1;
    n_tests++;
    if (dbg_data !== 16'h0000 || psw !== 16'h0000) begin
      n_fail++; $display("FAIL rstmid_clear R4=%h psw=%h, expected 0000 0000", dbg_data, psw);
    end
  endtask

  initial begin
    cst = '{16'h0000, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'hFFFF};
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_psw = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_add();
    test_const_add();
    test_cmp();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    wait_idle();
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover pending=%0d, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
